// File: rtl/cic_comp_pkg.sv
// Shared types and width helpers for the CIC compensation FIR.
// Optional rounding is selected with the CIC_COMP_ROUND_EN macro (see cic_comp_round_sat).
package cic_comp_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_FLUSH = 2'd2,
        S_OUT   = 2'd3
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

    // Full-precision accumulator width: one product plus growth for NUM_TAPS sums.
    function automatic int acc_dw(input int inp_dw, input int coef_dw, input int taps);
        return inp_dw + coef_dw + clog2(taps);
    endfunction

endpackage

// File: rtl/cic_comp_round_sat.sv
// Combinational shift/saturate from accumulator width to output width.
// With CIC_COMP_ROUND_EN defined, half an LSB is added first (round half up); otherwise floor.
module cic_comp_round_sat #(
    parameter int ACC_DW    = 40,
    parameter int OUT_DW    = 18,
    parameter int OUT_SHIFT = 16
) (
    input  logic signed [ACC_DW-1:0] acc_i,
    output logic signed [OUT_DW-1:0] y_o
);

    localparam logic signed [ACC_DW:0] MAX_V = {{(ACC_DW-OUT_DW+2){1'b0}}, {(OUT_DW-1){1'b1}}};
    localparam logic signed [ACC_DW:0] MIN_V = {{(ACC_DW-OUT_DW+2){1'b1}}, {(OUT_DW-1){1'b0}}};

    logic signed [ACC_DW:0] biased;
    logic signed [ACC_DW:0] shifted;

`ifdef CIC_COMP_ROUND_EN
    localparam logic signed [ACC_DW:0] HALF = (ACC_DW+1)'(1) << (OUT_SHIFT-1);
    // One extra bit of headroom so the bias can never wrap the accumulator.
    assign biased = (ACC_DW+1)'(acc_i) + HALF;
`else
    assign biased = (ACC_DW+1)'(acc_i);
`endif

    assign shifted = biased >>> OUT_SHIFT;

    always_comb begin
        y_o = shifted[OUT_DW-1:0];
        if (shifted > MAX_V) begin
            y_o = MAX_V[OUT_DW-1:0];
        end else if (shifted < MIN_V) begin
            y_o = MIN_V[OUT_DW-1:0];
        end
    end

endmodule

// File: rtl/cic_comp_fir.sv
// Serial-MAC FIR that flattens the CIC passband droop; one multiplier shared across all taps.
// Rounding of the output is enabled by defining CIC_COMP_ROUND_EN.
module cic_comp_fir
    import cic_comp_pkg::*;
#(
    parameter int INP_DW    = 18,
    parameter int OUT_DW    = 18,
    parameter int COEF_DW   = 18,
    parameter int NUM_TAPS  = 16,
    parameter int OUT_SHIFT = COEF_DW - 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic signed [INP_DW-1:0]  s_axis_in_tdata,
    input  logic                      s_axis_in_tvalid,
    input  logic signed [COEF_DW-1:0] s_axis_coef_tdata,
    input  logic                      s_axis_coef_tvalid,
    output logic signed [OUT_DW-1:0]  m_axis_out_tdata,
    output logic                      m_axis_out_tvalid,
    output logic                      overrun_err
);

    localparam int ACC_DW  = acc_dw(INP_DW, COEF_DW, NUM_TAPS);
    localparam int PROD_DW = INP_DW + COEF_DW;
    localparam int PW      = (clog2(NUM_TAPS) < 1) ? 1 : clog2(NUM_TAPS);
    localparam logic [PW-1:0] LAST = PW'(NUM_TAPS - 1);
    localparam logic signed [COEF_DW-1:0] UNITY = COEF_DW'(1) << OUT_SHIFT;

    state_e                    state_q, state_d;
    logic [PW-1:0]             k_q, k_d;
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             coef_ptr_q;
    logic [PW-1:0]             rd_idx;
    logic                      x_we;
    logic signed [INP_DW-1:0]  x_q    [NUM_TAPS];
    logic signed [COEF_DW-1:0] coef_q [NUM_TAPS];
    logic signed [PROD_DW-1:0] prod_q, prod_d;
    logic signed [ACC_DW-1:0]  acc_q, acc_d;
    logic signed [OUT_DW-1:0]  out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      overrun_q, overrun_d;
    logic signed [OUT_DW-1:0]  y_rs;

    // Modular wrap also holds for non-power-of-two lengths since the true index is < NUM_TAPS.
    assign rd_idx = (wr_ptr_q >= k_q) ? (wr_ptr_q - k_q) : (wr_ptr_q + PW'(NUM_TAPS) - k_q);

    cic_comp_round_sat #(
        .ACC_DW    (ACC_DW),
        .OUT_DW    (OUT_DW),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_round_sat (
        .acc_i (acc_q),
        .y_o   (y_rs)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        wr_ptr_d    = wr_ptr_q;
        x_we        = 1'b0;
        prod_d      = prod_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;
        case (state_q)
            S_IDLE, S_OUT: begin
                if (state_q == S_OUT) begin
                    out_valid_d = 1'b1;
                    out_data_d  = y_rs;
                end
                state_d = S_IDLE;
                if (s_axis_in_tvalid) begin
                    x_we     = 1'b1;
                    wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
                    acc_d    = '0;
                    prod_d   = '0;
                    k_d      = '0;
                    state_d  = S_MAC;
                end
            end
            S_MAC: begin
                prod_d = PROD_DW'(coef_q[k_q]) * PROD_DW'(x_q[rd_idx]);
                acc_d  = acc_q + ACC_DW'(prod_q);
                if (k_q == LAST) begin
                    state_d = S_FLUSH;
                end else begin
                    k_d = k_q + 1'b1;
                end
                if (s_axis_in_tvalid) overrun_d = 1'b1;
            end
            S_FLUSH: begin
                acc_d   = acc_q + ACC_DW'(prod_q);
                state_d = S_OUT;
                if (s_axis_in_tvalid) overrun_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            wr_ptr_q    <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wr_ptr_q    <= wr_ptr_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // The new sample lands at the advanced pointer so tap 0 always reads the newest one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_TAPS; i++) x_q[i] <= '0;
        end else if (x_we) begin
            x_q[wr_ptr_d] <= s_axis_in_tdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            coef_ptr_q <= '0;
            for (int i = 0; i < NUM_TAPS; i++) coef_q[i] <= (i == 0) ? UNITY : '0;
        end else if (s_axis_coef_tvalid) begin
            coef_q[coef_ptr_q] <= s_axis_coef_tdata;
            coef_ptr_q         <= (coef_ptr_q == LAST) ? '0 : coef_ptr_q + 1'b1;
        end
    end

    assign m_axis_out_tdata  = out_data_q;
    assign m_axis_out_tvalid = out_valid_q;
    assign overrun_err       = overrun_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Scoreboard bench for cic_comp_fir: stimulus pushes expected samples, a monitor pops on each output strobe.
module tb_cic_comp_fir;

    localparam int NT = 16;

    logic               clk;
    logic               reset_n;
    logic signed [17:0] in_data;
    logic               in_valid;
    logic signed [17:0] coef_data;
    logic               coef_valid;
    logic signed [17:0] out_data;
    logic               out_valid;
    logic               overrun;

    typedef struct {
        int d;
        int c;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    cic_comp_fir dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .s_axis_in_tdata    (in_data),
        .s_axis_in_tvalid   (in_valid),
        .s_axis_coef_tdata  (coef_data),
        .s_axis_coef_tvalid (coef_valid),
        .m_axis_out_tdata   (out_data),
        .m_axis_out_tvalid  (out_valid),
        .overrun_err        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
        end else begin
            $display("ok   %s = %0d (cycle %0d)", name, got, cyc);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output got=%0d want=none (cycle %0d)", $signed(out_data), cyc);
                end else begin
                    e = q.pop_front();
                    check("out_data", int'($signed(out_data)), e.d);
                    check("out_latency", cyc, e.c);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Output strobe is expected at the negedge following edge (accept + NT + 2).
    task automatic send(input int v, input bit expect_out, input int ev);
        exp_t e;
        @(negedge clk);
        in_data  = 18'(v);
        in_valid = 1'b1;
        if (expect_out) begin
            e.d = ev;
            e.c = cyc + 1 + NT + 2;
            q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_coefs(input int cs[NT]);
        for (int i = 0; i < NT; i++) begin
            @(negedge clk);
            coef_data  = 18'(cs[i]);
            coef_valid = 1'b1;
        end
        @(negedge clk);
        coef_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'($signed(out_data)), 0);
        check("rst_overrun", int'(overrun), 0);
    endtask

    initial begin
        int cs[NT];
        int rnd_pos;
        int rnd_neg;
        in_data    = '0;
        in_valid   = 1'b0;
        coef_data  = '0;
        coef_valid = 1'b0;
        reset_n    = 1'b0;
        idle(3);
        reset_n = 1'b1;
        check("init_out_valid", int'(out_valid), 0);
        check("init_overrun", int'(overrun), 0);

        // Reset pass-through
        send(1000, 1'b1, 1000);
        idle(25);
        check("pass_overrun", int'(overrun), 0);

        // Two-tap moving sum
        do_reset();
        foreach (cs[i]) cs[i] = (i < 2) ? 65536 : 0;
        load_coefs(cs);
        send(100, 1'b1, 100); idle(19);
        send(200, 1'b1, 300); idle(19);
        send(300, 1'b1, 500); idle(25);

        // Saturation, both rails
        do_reset();
        foreach (cs[i]) cs[i] = (i < 4) ? 65536 : 0;
        load_coefs(cs);
        for (int i = 0; i < 4; i++) begin
            send(131071, 1'b1, 131071); idle(19);
        end
        send(-131072, 1'b1, 131071);  idle(19);
        send(-131072, 1'b1, -2);      idle(19);
        send(-131072, 1'b1, -131072); idle(19);
        send(-131072, 1'b1, -131072); idle(25);

        // Overrun: second sample 5 cycles after the first is dropped
        do_reset();
        send(50, 1'b1, 50);
        idle(3);
        send(77, 1'b0, 0);
        idle(25);
        check("overrun_set", int'(overrun), 1);
        send(0, 1'b1, 0);
        idle(25);
        check("overrun_sticky", int'(overrun), 1);

        // Rounding with a half-gain tap
        do_reset();
`ifdef CIC_COMP_ROUND_EN
        rnd_pos = 2;
        rnd_neg = -1;
`else
        rnd_pos = 1;
        rnd_neg = -2;
`endif
        foreach (cs[i]) cs[i] = (i == 0) ? 32768 : 0;
        load_coefs(cs);
        send(3, 1'b1, rnd_pos);  idle(19);
        send(-3, 1'b1, rnd_neg); idle(25);

        // Reset mid-MAC aborts the sample and restores pass-through coefficients
        send(9, 1'b0, 0);
        idle(3);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        check("abort_overrun", int'(overrun), 0);
        send(7, 1'b1, 7);
        idle(25);

        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        check("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cic_comp_fir.md
Name: cic_comp_fir

Overview:
Serial-MAC FIR compensation filter placed directly downstream of cic_d. It consumes the CIC decimated output stream and flattens the CIC sinc^N passband droop. Because the CIC output rate is at most clk/(R) with R ≥ NUM_TAPS+2, a single time-multiplexed multiplier-accumulator is used. Coefficients are runtime-loadable, and the filter resets to a unity pass-through.

Parameters:
INP_DW, 18, input sample width (signed); matches cic_d OUT_DW.
OUT_DW, 18, output sample width (signed).
COEF_DW, 18, coefficient width (signed).
NUM_TAPS, 16, filter length, ≥2.
OUT_SHIFT, COEF_DW-2, arithmetic right shift applied to the accumulator before saturation; unity coefficient = 2**OUT_SHIFT.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
s_axis_in_tdata  in  INP_DW  signed input sample
s_axis_in_tvalid  in  1  input strobe, single cycle, no ready
s_axis_coef_tdata  in  COEF_DW  signed coefficient
s_axis_coef_tvalid  in  1  coefficient write strobe
m_axis_out_tdata  out  OUT_DW  signed filtered sample, held between strobes
m_axis_out_tvalid  out  1  output strobe, one cycle per accepted input
overrun_err  out  1  sticky flag: input sample dropped

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset: all outputs 0. Delay line all 0. Coefficient pointer 0. Coefficients: coef[0]=2**OUT_SHIFT, all others 0, which gives unity pass-through. State IDLE.
- ACC_DW = INP_DW+COEF_DW+clog2(NUM_TAPS). Products and accumulation are full precision; no overflow is possible inside the accumulator.
- Delay line: circular buffer of NUM_TAPS words with write pointer wr_ptr. Tap k reads x[(wr_ptr-k) mod NUM_TAPS].
- FSM states: IDLE, MAC, FLUSH, OUT.
  - IDLE or OUT, with s_axis_in_tvalid=1: write the sample, clear the accumulator, k=0, go to MAC. Otherwise OUT goes to IDLE.
  - MAC: register one product per cycle (product pipe 1 deep) and accumulate the previous product. After k=NUM_TAPS-1, go to FLUSH.
  - FLUSH: add the last product, go to OUT.
  - OUT: register the rounded/saturated result and pulse m_axis_out_tvalid for exactly 1 cycle.
- Latency: with the input accepted at edge 0, m_axis_out_tvalid is high in the cycle after edge NUM_TAPS+2. Minimum input spacing is NUM_TAPS+2 cycles.
- Overrun: s_axis_in_tvalid in MAC or FLUSH drops the sample (delay line unchanged) and sets overrun_err. The flag clears only on reset. The in-progress computation completes normally.
- Output arithmetic: y = acc >>> OUT_SHIFT (floor), then saturate to [-2**(OUT_DW-1), 2**(OUT_DW-1)-1].
- Coefficient load: each s_axis_coef_tvalid writes coef[coef_ptr] and increments the pointer, which wraps NUM_TAPS-1→0. Writes are accepted in any state and take effect at the next edge. An output whose MAC window overlaps a write is unspecified.
- Reset mid-operation: the FSM aborts to IDLE, and no m_axis_out_tvalid is issued for the aborted sample.

Optional Feature:
- Macro: CIC_COMP_ROUND_EN.
- Defined: add 2**(OUT_SHIFT-1) to the accumulator before the shift (round half up), then saturate. This adds no latency.
- Undefined: floor truncation only.

Decomposition:
- Package cic_comp_pkg: FSM state enum, clog2 helper, ACC_DW computation function.
- One sub-module, cic_comp_round_sat: combinational round/shift/saturate from ACC_DW to OUT_DW. It is parameterised by OUT_SHIFT and honours CIC_COMP_ROUND_EN.
- Top-level cic_comp_fir: FSM, delay line, coefficient RAM, MAC.

Test Plan:
- Reset pass-through: after reset, input 1000 at edge 0 → output 1000, tvalid exactly NUM_TAPS+2 cycles later; overrun_err=0.
- Two-tap load: write coef 65536, 65536, then 14 zeros; inputs 100, 200, 300 spaced 20 cycles → outputs 100, 300, 500.
- Saturation: coef[0..3]=65536; four inputs 131071 → 4th output 131071 (clamped). Four inputs -131072 → -131072.
- Overrun: second input 5 cycles after first → exactly one output, overrun_err=1 until reset, delay line unchanged (next valid input 0 → output 0 with pass-through coefs).
- Rounding: coef[0]=32768 (0.5). Input 3 → 1 (undefined) / 2 (defined). Input -3 → -2 (undefined) / -1 (defined).
- Reset mid-MAC: drop reset_n 4 cycles after an input → no tvalid pulse. Coefs return to pass-through, so input 7 → output 7.
